// File: rtl/vga_pkg.sv
// Shared constants and phase type for the VGA raster timing generator.
// Defaults describe 640x480@60 with a 25 MHz pixel rate.
package vga_pkg;

  localparam int DEF_ACTIVE_COLS = 640;
  localparam int DEF_ACTIVE_ROWS = 480;
  localparam int DEF_H_FP        = 16;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BP        = 48;
  localparam int DEF_V_FP        = 10;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BP        = 33;
  localparam bit DEF_SYNC_POL    = 1'b0;

  localparam int DEF_H_TOTAL = DEF_ACTIVE_COLS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_ACTIVE_ROWS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FP,
    PH_SYNC,
    PH_BP
  } phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FP/SYNC/BP phase FSM.
// The phase FSM state is exported on the phase output.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  localparam int TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int CW    = $clog2(TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  output logic [CW-1:0] cnt,
  output phase_t        phase,
  output logic          wrap
);

  // Last count of each phase; the FSM leaves a phase after its final count.
  localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] FP_END   = CW'(ACTIVE + FP - 1);
  localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FP + SYNC - 1);
  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);

  logic [CW-1:0] cnt_nxt;
  phase_t        phase_nxt;

  assign wrap = (cnt == LAST);

  always_comb begin
    cnt_nxt   = wrap ? '0 : cnt + 1'b1;
    phase_nxt = phase;
    case (phase)
      PH_ACTIVE: if (cnt == ACT_END)  phase_nxt = PH_FP;
      PH_FP:     if (cnt == FP_END)   phase_nxt = PH_SYNC;
      PH_SYNC:   if (cnt == SYNC_END) phase_nxt = PH_BP;
      PH_BP:     if (cnt == LAST)     phase_nxt = PH_ACTIVE;
      default:                        phase_nxt = PH_ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= PH_ACTIVE;
    end else if (adv) begin
      cnt   <= cnt_nxt;
      phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: registered hsync/vsync/active/row/col and line/frame pulses.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter bit SYNC_POL    = DEF_SYNC_POL
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pix_en,
  output logic                           hsync,
  output logic                           vsync,
  output logic                           active,
  output logic [$clog2(ACTIVE_ROWS)-1:0] row,
  output logic [$clog2(ACTIVE_COLS)-1:0] col,
  output logic                           line_start,
  output logic                           frame_start,
  output logic [7:0]                     frame_cnt
);

  localparam int HW    = $clog2(ACTIVE_COLS + H_FP + H_SYNC + H_BP);
  localparam int VW    = $clog2(ACTIVE_ROWS + V_FP + V_SYNC + V_BP);
  localparam int ROW_W = $clog2(ACTIVE_ROWS);
  localparam int COL_W = $clog2(ACTIVE_COLS);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  phase_t        h_phase;
  phase_t        v_phase;
  logic          h_wrap;
  logic          unused_v_wrap;
  logic          vis;
  logic          at_line0;
  logic          at_frame0;

  vga_axis_counter #(
    .ACTIVE (ACTIVE_COLS),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (pix_en),
    .cnt   (h_cnt),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  // Vertical axis steps once per line, on the horizontal wrap.
  vga_axis_counter #(
    .ACTIVE (ACTIVE_ROWS),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (pix_en && h_wrap),
    .cnt   (v_cnt),
    .phase (v_phase),
    .wrap  (unused_v_wrap)
  );

  assign vis       = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
  assign at_line0  = (h_cnt == '0);
  assign at_frame0 = at_line0 && (v_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      active      <= 1'b0;
      row         <= '0;
      col         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Pulses are strictly one clock wide, even when pix_en stays low afterwards.
      line_start  <= pix_en && at_line0;
      frame_start <= pix_en && at_frame0;
      if (pix_en) begin
        hsync  <= (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        vsync  <= (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        active <= vis;
        row    <= vis ? v_cnt[ROW_W-1:0] : '0;
        col    <= vis ? h_cnt[COL_W-1:0] : '0;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (pix_en && at_frame0) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, small and tiny geometries checked against a raster model.
module tb_vga_timing_gen;

  localparam int NI = 3;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        active;
    logic [15:0] row;
    logic [15:0] col;
    logic        line_start;
    logic        frame_start;
    logic [7:0]  frame_cnt;
  } obs_t;

  // Instance 0: defaults, 1: 16x8 small, 2: 4x3 tiny
  int p_ac[NI]  = '{640, 16, 4};
  int p_hfp[NI] = '{16, 2, 1};
  int p_hsy[NI] = '{96, 3, 1};
  int p_hbp[NI] = '{48, 4, 1};
  int p_ar[NI]  = '{480, 8, 3};
  int p_vfp[NI] = '{10, 2, 1};
  int p_vsy[NI] = '{2, 2, 1};
  int p_vbp[NI] = '{33, 3, 1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_v;
  logic [NI-1:0] en_v;
  logic          chk_on = 1'b0;
  int            n_cmp  = 0;
  int            n_bad  = 0;

  logic       d_hs, d_vs, d_act, d_ls, d_fs;
  logic [8:0] d_row;
  logic [9:0] d_col;
  logic [7:0] d_fc;
  logic       s_hs, s_vs, s_act, s_ls, s_fs;
  logic [2:0] s_row;
  logic [3:0] s_col;
  logic [7:0] s_fc;
  logic       t_hs, t_vs, t_act, t_ls, t_fs;
  logic [1:0] t_row;
  logic [1:0] t_col;
  logic [7:0] t_fc;

  vga_timing_gen u_dut_d (
    .clk(clk), .rst_n(rst_v[0]), .pix_en(en_v[0]),
    .hsync(d_hs), .vsync(d_vs), .active(d_act), .row(d_row), .col(d_col),
    .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
  );

  vga_timing_gen #(
    .ACTIVE_COLS(16), .ACTIVE_ROWS(8), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u_dut_s (
    .clk(clk), .rst_n(rst_v[1]), .pix_en(en_v[1]),
    .hsync(s_hs), .vsync(s_vs), .active(s_act), .row(s_row), .col(s_col),
    .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
  );

  vga_timing_gen #(
    .ACTIVE_COLS(4), .ACTIVE_ROWS(3), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) u_dut_t (
    .clk(clk), .rst_n(rst_v[2]), .pix_en(en_v[2]),
    .hsync(t_hs), .vsync(t_vs), .active(t_act), .row(t_row), .col(t_col),
    .line_start(t_ls), .frame_start(t_fs), .frame_cnt(t_fc)
  );

  obs_t obs[NI];
  assign obs[0] = {d_hs, d_vs, d_act, 16'(d_row), 16'(d_col), d_ls, d_fs, d_fc};
  assign obs[1] = {s_hs, s_vs, s_act, 16'(s_row), 16'(s_col), s_ls, s_fs, s_fc};
  assign obs[2] = {t_hs, t_vs, t_act, 16'(t_row), 16'(t_col), t_ls, t_fs, t_fc};

  // ---------------- raster model ----------------
  int   mh[NI];
  int   mv[NI];
  int   mfc[NI];
  obs_t exp_o[NI];

  function automatic int htot(int k);
    return p_ac[k] + p_hfp[k] + p_hsy[k] + p_hbp[k];
  endfunction

  function automatic int vtot(int k);
    return p_ar[k] + p_vfp[k] + p_vsy[k] + p_vbp[k];
  endfunction

  function automatic obs_t rst_obs();
    obs_t o;
    o = '0;
    o.hsync = 1'b1;
    o.vsync = 1'b1;
    return o;
  endfunction

  function automatic obs_t hold(obs_t o_in);
    obs_t o;
    o = o_in;
    o.line_start  = 1'b0;
    o.frame_start = 1'b0;
    return o;
  endfunction

  // What the outputs must show once position (h,v) has been registered.
  function automatic obs_t decode(int k, int h, int v, int fc);
    obs_t o;
    int   hs0;
    int   vs0;
    logic vis;
    o   = '0;
    hs0 = p_ac[k] + p_hfp[k];
    vs0 = p_ar[k] + p_vfp[k];
    vis = (h < p_ac[k]) && (v < p_ar[k]);
    o.active      = vis;
    o.hsync       = !(h >= hs0 && h < hs0 + p_hsy[k]);
    o.vsync       = !(v >= vs0 && v < vs0 + p_vsy[k]);
    o.row         = vis ? 16'(v) : 16'd0;
    o.col         = vis ? 16'(h) : 16'd0;
    o.line_start  = (h == 0);
    o.frame_start = (h == 0 && v == 0);
    o.frame_cnt   = FC_EN ? 8'((h == 0 && v == 0) ? fc + 1 : fc) : 8'd0;
    return o;
  endfunction

  function automatic obs_t expect_now(int k);
    return rst_v[k] ? exp_o[k] : rst_obs();
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("hs=%b vs=%b act=%b row=%0d col=%0d ls=%b fs=%b fc=%0d",
                     o.hsync, o.vsync, o.active, o.row, o.col,
                     o.line_start, o.frame_start, o.frame_cnt);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_v[k]) begin
        mh[k]    <= 0;
        mv[k]    <= 0;
        mfc[k]   <= 0;
        exp_o[k] <= rst_obs();
      end else if (en_v[k]) begin
        exp_o[k] <= decode(k, mh[k], mv[k], mfc[k]);
        mfc[k]   <= (mh[k] == 0 && mv[k] == 0) ? (mfc[k] + 1) % 256 : mfc[k];
        mh[k]    <= (mh[k] == htot(k) - 1) ? 0 : mh[k] + 1;
        mv[k]    <= (mh[k] == htot(k) - 1) ? ((mv[k] == vtot(k) - 1) ? 0 : mv[k] + 1) : mv[k];
      end else begin
        exp_o[k] <= hold(exp_o[k]);
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if (obs[k] !== expect_now(k)) begin
          n_bad++;
          $display("FAIL model_cmp inst%0d t=%0t: got {%s} expected {%s}",
                   k, $time, fmt(obs[k]), fmt(expect_now(k)));
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int act_n, hs_n, hs_first, ls_next, late_n, vs_n, vs_first, fs_next;
    int fs0, fs1, ls_prev, ls_bad, wide_n, fs_seen;
    logic ls_last;
    logic found;

    rst_v = '0;
    en_v  = '0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("rst_hsync",  32'(d_hs), 1);
    check("rst_vsync",  32'(d_vs), 1);
    check("rst_active", 32'(d_act), 0);
    check("rst_ls",     32'(d_ls), 0);
    check("rst_fc",     32'(d_fc), 0);

    // Default geometry: first registered cycle and one full line
    rst_v[0] = 1'b1;
    en_v[0]  = 1'b1;
    @(negedge clk);
    check("first_active", 32'(d_act), 1);
    check("first_row",    32'(d_row), 0);
    check("first_col",    32'(d_col), 0);
    check("first_fs",     32'(d_fs), 1);
    check("first_ls",     32'(d_ls), 1);
    check("first_hsync",  32'(d_hs), 1);
    check("first_vsync",  32'(d_vs), 1);
    act_n = 0; hs_n = 0; hs_first = -1; ls_next = -1;
    for (int i = 0; i < 900; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 800 && d_act) act_n++;
      if (i < 800 && !d_hs) begin
        if (hs_first < 0) hs_first = i;
        hs_n++;
      end
      if (i > 0 && d_ls && ls_next < 0) ls_next = i;
    end
    en_v[0] = 1'b0;
    check("line_active_cycles", act_n, 640);
    check("hsync_low_cycles",   hs_n, 96);
    check("hsync_start",        hs_first, 656);
    check("line_period",        ls_next, 800);

    // Small geometry (25x15): full frame with pix_en high
    rst_v[1] = 1'b1;
    en_v[1]  = 1'b1;
    @(negedge clk);
    check("s_first_fs", 32'(s_fs), 1);
    act_n = 0; late_n = 0; vs_n = 0; vs_first = -1; fs_next = -1;
    for (int i = 0; i < 400; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 375) begin
        if (s_act) act_n++;
        if (s_act && i / 25 >= 8) late_n++;
        if (!s_vs) begin
          if (vs_first < 0) vs_first = i;
          vs_n++;
        end
      end
      if (i > 0 && s_fs && fs_next < 0) fs_next = i;
    end
    check("frame_period",      fs_next, 375);
    check("frame_active",      act_n, 128);
    check("active_late_lines", late_n, 0);
    check("vsync_low_cycles",  vs_n, 50);
    check("vsync_start",       vs_first, 250);

    // pix_en toggled every clock: periods double, pulses stay one clock
    fs0 = -1; fs1 = -1; ls_prev = -1; ls_bad = 0; wide_n = 0; vs_n = 0; ls_last = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (s_fs) begin
        if (fs0 < 0) fs0 = i;
        else if (fs1 < 0) fs1 = i;
      end
      if (fs0 >= 0 && fs1 < 0 && !s_vs) vs_n++;
      if (s_ls) begin
        if (ls_prev >= 0 && i - ls_prev != 50) ls_bad++;
        ls_prev = i;
      end
      if (s_ls && ls_last) wide_n++;
      ls_last = s_ls;
      en_v[1] = ~en_v[1];
    end
    en_v[1] = 1'b1;
    check("half_rate_frame_period", fs1 - fs0, 750);
    check("half_rate_line_period",  ls_bad, 0);
    check("half_rate_vsync_low",    vs_n, 100);
    check("pulse_width",            wide_n, 0);

    // Asynchronous reset in the middle of active video
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (s_row == 3'd5 && s_col == 4'd10) found = 1'b1;
    end
    check("reach_row5_col10", 32'(found), 1);
    #2 rst_v[1] = 1'b0;
    #1;
    check("async_rst_active", 32'(s_act), 0);
    check("async_rst_row",    32'(s_row), 0);
    check("async_rst_col",    32'(s_col), 0);
    repeat (2) @(negedge clk);
    rst_v[1] = 1'b1;

    // Asynchronous reset while both sync pulses are asserted
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (!s_hs && !s_vs) found = 1'b1;
    end
    check("reach_sync", 32'(found), 1);
    #2 rst_v[1] = 1'b0;
    #1;
    check("async_rst_hsync", 32'(s_hs), 1);
    check("async_rst_vsync", 32'(s_vs), 1);
    repeat (2) @(negedge clk);
    rst_v[1] = 1'b1;
    @(negedge clk);
    check("restart_active", 32'(s_act), 1);
    check("restart_row",    32'(s_row), 0);
    check("restart_col",    32'(s_col), 0);
    check("restart_fs",     32'(s_fs), 1);
    en_v[1] = 1'b0;

    // Tiny geometry (7x6 = 42 clocks/frame): frame counter across wrap
    rst_v[2] = 1'b1;
    en_v[2]  = 1'b1;
    fs_seen  = 0;
    for (int i = 0; i < 42 * 258; i++) begin
      @(negedge clk);
      if (t_fs) begin
        fs_seen++;
        if (fs_seen == 1)   check("fc_frame1",   32'(t_fc), FC_EN ? 1 : 0);
        if (fs_seen == 255) check("fc_frame255", 32'(t_fc), FC_EN ? 255 : 0);
        if (fs_seen == 256) check("fc_wrap",     32'(t_fc), 0);
        if (fs_seen == 257) check("fc_after",    32'(t_fc), FC_EN ? 1 : 0);
      end
    end
    check("tiny_frames", fs_seen, 258);
    en_v[2] = 1'b0;

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
